int_div_iter_64b: RTL and testbench

Iterative 64-bit integer divider that produces one quotient bit per cycle using a restoring shift-subtract loop. Each iteration resolves its trial subtraction through a single-cycle 64-bit parallel-prefix subtractor. The block sits beside the 64-bit adder in the execute datapath, exchanging operands and results over valid/ready handshakes. It handles RISC-V-style divide-by-zero and signed-overflow corner cases.

---
 rtl/div_pkg.sv | 16 +
 rtl/sub_prefix_64b.sv | 67 ++++++
 rtl/int_div_iter_64b.sv | 173 +++++++++++++++++
 tb/tb_int_div_iter_64b.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 64-bit divider.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        POST,
        DONE
    } div_state_e;

    localparam int unsigned DIV_WIDTH     = 64;
    localparam int unsigned DIV_ITER_LAST = 63;
    localparam logic [63:0] DIV_SMIN      = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/sub_prefix_64b.sv
// 64-bit subtractor a - b built as a + ~b + 1 on a Brent-Kung prefix tree.
// borrow_o is set when b > a (unsigned).
module sub_prefix_64b
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] a_i,
    input  logic [DIV_WIDTH-1:0] b_i,
    output logic [DIV_WIDTH-1:0] diff_o,
    output logic                 borrow_o
);

    localparam int LOGW = $clog2(DIV_WIDTH);

    logic [DIV_WIDTH-1:0] p;
    logic [DIV_WIDTH-1:0] g;
    logic [DIV_WIDTH-1:0] gfin;
    logic                 unused_ptop;

    assign p = a_i ^ ~b_i;
    assign g = a_i & ~b_i;

    // Up-sweep: black cells build power-of-two group terms.
    for (genvar l = 0; l <= LOGW; l++) begin : g_up
        logic [DIV_WIDTH-1:0] gg;
        logic [DIV_WIDTH-1:0] pp;
        if (l == 0) begin : g_base
            // The +1 carry-in folds into bit 0's generate.
            assign gg = {g[DIV_WIDTH-1:1], g[0] | p[0]};
            assign pp = p;
        end else begin : g_lvl
            for (genvar i = 0; i < DIV_WIDTH; i++) begin : g_bit
                if ((i + 1) % (2 << (l - 1)) == 0) begin : g_blk
                    assign gg[i] = g_up[l-1].gg[i]
                                 | (g_up[l-1].pp[i] & g_up[l-1].gg[i-(1<<(l-1))]);
                    assign pp[i] = g_up[l-1].pp[i] & g_up[l-1].pp[i-(1<<(l-1))];
                end else begin : g_pass
                    assign gg[i] = g_up[l-1].gg[i];
                    assign pp[i] = g_up[l-1].pp[i];
                end
            end
        end
    end

    // Down-sweep: gray cells fill in the remaining prefixes.
    for (genvar d = 0; d < LOGW; d++) begin : g_dn
        logic [DIV_WIDTH-1:0] gg;
        if (d == 0) begin : g_base
            assign gg = g_up[LOGW].gg;
        end else begin : g_lvl
            localparam int S = 1 << (LOGW - 1 - d);
            for (genvar i = 0; i < DIV_WIDTH; i++) begin : g_bit
                if (((i + 1) % (2 * S) == S) && (i >= 2 * S)) begin : g_gray
                    assign gg[i] = g_dn[d-1].gg[i]
                                 | (g_up[LOGW].pp[i] & g_dn[d-1].gg[i-S]);
                end else begin : g_pass
                    assign gg[i] = g_dn[d-1].gg[i];
                end
            end
        end
    end

    assign gfin        = g_dn[LOGW-1].gg;
    assign unused_ptop = ^g_up[LOGW].pp;
    assign diff_o      = p ^ {gfin[DIV_WIDTH-2:0], 1'b1};
    assign borrow_o    = ~gfin[DIV_WIDTH-1];

endmodule

// File: rtl/int_div_iter_64b.sv
// Iterative restoring 64-bit divider, one quotient bit per cycle, with valid/ready handshakes.
// Define DIV_SIGNED_EN for two's-complement support; otherwise signed_i is ignored.
module int_div_iter_64b
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             signed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_zero_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    div_state_e       state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rmd_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             dz_q;

    logic [WIDTH:0]   shifted_d;
    logic [WIDTH-1:0] sub_a_d;
    logic [WIDTH-1:0] sub_b_d;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_borrow;
    logic             q_bit_d;
    logic [WIDTH-1:0] rem_d;

    // Shared subtractor: trial subtraction in ITER, 0 - q_q in PREP/POST.
    always_comb begin
        shifted_d = {rem_q, q_q[WIDTH-1]};
        sub_a_d   = (state_q == ITER) ? shifted_d[WIDTH-1:0] : '0;
        sub_b_d   = (state_q == ITER) ? b_q : q_q;
    end

    sub_prefix_64b u_sub (
        .a_i      (sub_a_d),
        .b_i      (sub_b_d),
        .diff_o   (sub_diff),
        .borrow_o (sub_borrow)
    );

    // A set bit W means shifted >= 2^W > divisor, so the low W bits of the difference are exact.
    assign q_bit_d = shifted_d[WIDTH] | ~sub_borrow;
    assign rem_d   = q_bit_d ? sub_diff : shifted_d[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    logic             sgn_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH-1:0] aux_diff;
    logic             unused_aux_borrow;

    // Second negator: divisor magnitude in PREP, remainder sign fix-up in POST.
    sub_prefix_64b u_neg (
        .a_i      ('0),
        .b_i      ((state_q == PREP) ? b_q : rem_q),
        .diff_o   (aux_diff),
        .borrow_o (unused_aux_borrow)
    );
`else
    logic unused_signed;
    assign unused_signed = signed_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quo_q       <= '0;
            rmd_q       <= '0;
            dz_q        <= 1'b0;
            cnt_q       <= '0;
            q_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
`ifdef DIV_SIGNED_EN
            sgn_q       <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        q_q        <= dividend_i;
                        b_q        <= divisor_i;
                        in_ready_q <= 1'b0;
                        state_q    <= PREP;
`ifdef DIV_SIGNED_EN
                        sgn_q      <= signed_i;
`endif
                    end
                end
                PREP: begin
                    if (b_q == '0) begin
                        quo_q       <= '1;
                        rmd_q       <= q_q;
                        dz_q        <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef DIV_SIGNED_EN
                    end else if (sgn_q && (q_q == DIV_SMIN) && (b_q == '1)) begin
                        quo_q       <= DIV_SMIN;
                        rmd_q       <= '0;
                        dz_q        <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`endif
                    end else begin
`ifdef DIV_SIGNED_EN
                        neg_q_q <= sgn_q & (q_q[WIDTH-1] ^ b_q[WIDTH-1]);
                        neg_r_q <= sgn_q & q_q[WIDTH-1];
                        if (sgn_q && q_q[WIDTH-1]) q_q <= sub_diff;
                        if (sgn_q && b_q[WIDTH-1]) b_q <= aux_diff;
`endif
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    rem_q <= rem_d;
                    q_q   <= {q_q[WIDTH-2:0], q_bit_d};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DIV_ITER_LAST)) state_q <= POST;
                end
                POST: begin
`ifdef DIV_SIGNED_EN
                    quo_q <= neg_q_q ? sub_diff : q_q;
                    rmd_q <= neg_r_q ? aux_diff : rem_q;
`else
                    quo_q <= q_q;
                    rmd_q <= rem_q;
`endif
                    dz_q        <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign quotient_o  = quo_q;
    assign remainder_o = rmd_q;
    assign div_zero_o  = dz_q;

endmodule

// File: tb/tb_int_div_iter_64b.sv
// Self-checking bench for int_div_iter_64b: directed vectors, arithmetic reference model, per-cycle monitor.
module tb_int_div_iter_64b;

    localparam logic [63:0] SMIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready_o;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        signed_in;
    logic        out_valid_o;
    logic        out_ready;
    logic [63:0] quotient_o;
    logic [63:0] remainder_o;
    logic        div_zero_o;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    logic [63:0] exp_q;
    logic [63:0] exp_r;
    logic        exp_dz;
    bit          have_exp = 1'b0;

    int_div_iter_64b #(.WIDTH(64)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .signed_i    (signed_in),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .div_zero_o  (div_zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%016h, required 0x%016h", name, act, req);
        end
    endtask

    // Reference: plain arithmetic plus the two architectural corner cases.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                  output logic [63:0] q, output logic [63:0] r, output logic dz);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        bit sg;
        sg = s && SIGNED_EN;
        sa = a;
        sb = b;
        dz = 1'b0;
        if (b == 64'd0) begin
            q = ONES; r = a; dz = 1'b1;
        end else if (sg && a == SMIN && b == ONES) begin
            q = SMIN; r = 64'd0;
        end else if (sg) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid_o && !have_exp)
            chk("out_valid without pending op", {63'd0, out_valid_o}, {63'd0, have_exp});
        if (!rst && out_valid_o && have_exp) begin
            chk("mon quotient", quotient_o, exp_q);
            chk("mon remainder", remainder_o, exp_r);
            chk("mon div_zero", {63'd0, div_zero_o}, {63'd0, exp_dz});
            chk("mon in_ready while valid", {63'd0, in_ready_o}, 64'd0);
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input bit early);
        int n;
        n = 0;
        while (!in_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready before issue", {63'd0, in_ready_o}, 64'd1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        signed_in = s;
        out_ready = early;
        @(posedge clk);
        model(a, b, s, exp_q, exp_r, exp_dz);
        have_exp = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 64'd0;
        divisor  = 64'd0;
    endtask

    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic [63:0] lit_q, input logic [63:0] lit_r,
                          input logic lit_dz, input int lat, input int hold, input bit early);
        logic [63:0] mq;
        logic [63:0] mr;
        logic        mdz;
        int          n;
        model(a, b, s, mq, mr, mdz);
        chk({name, " model quotient"}, mq, lit_q);
        chk({name, " model remainder"}, mr, lit_r);
        chk({name, " model div_zero"}, {63'd0, mdz}, {63'd0, lit_dz});
        issue(a, b, s, early);
        n = 1;
        while (!out_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(lat));
        chk({name, " quotient"}, quotient_o, lit_q);
        chk({name, " remainder"}, remainder_o, lit_r);
        chk({name, " div_zero"}, {63'd0, div_zero_o}, {63'd0, lit_dz});
        if (!early) begin
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk({name, " valid drops after consume"}, {63'd0, out_valid_o}, 64'd0);
        chk({name, " in_ready after consume"}, {63'd0, in_ready_o}, 64'd1);
        out_ready = 1'b0;
        have_exp  = 1'b0;
    endtask

    task automatic check_reset_values(input string name);
        chk({name, " in_ready"}, {63'd0, in_ready_o}, 64'd1);
        chk({name, " out_valid"}, {63'd0, out_valid_o}, 64'd0);
        chk({name, " quotient"}, quotient_o, 64'd0);
        chk({name, " remainder"}, remainder_o, 64'd0);
        chk({name, " div_zero"}, {63'd0, div_zero_o}, 64'd0);
    endtask

    task automatic reset_mid_iter();
        issue(64'd1000, 64'd3, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        chk("rst-mid busy in_ready", {63'd0, in_ready_o}, 64'd0);
        chk("rst-mid no early valid", {63'd0, out_valid_o}, 64'd0);
        rst      = 1'b1;
        have_exp = 1'b0;
        @(negedge clk);
        check_reset_values("rst-mid");
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = 64'd0;
        divisor   = 64'd0;
        signed_in = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op("u100/7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 67, 10, 1'b0);
        run_op("-100/7", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1,
               SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFF2 : 64'd2635249153387078788,
               SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd0, 1'b0, 67, 0, 1'b1);
        run_op("100/-7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
               SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFF2 : 64'd0,
               SIGNED_EN ? 64'd2 : 64'd100, 1'b0, 67, 2, 1'b0);
        run_op("-100/-7", 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1,
               SIGNED_EN ? 64'd14 : 64'd0,
               SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFFE : 64'hFFFF_FFFF_FFFF_FF9C, 1'b0, 67, 0, 1'b1);
        run_op("div0", 64'h1234, 64'd0, 1'b0, ONES, 64'h1234, 1'b1, 2, 0, 1'b1);
        run_op("sdiv0", 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, ONES, 64'hFFFF_FFFF_FFFF_FFFB,
               1'b1, 2, 3, 1'b0);
        run_op("smin/-1", SMIN, ONES, 1'b1,
               SIGNED_EN ? SMIN : 64'd0, SIGNED_EN ? 64'd0 : SMIN, 1'b0,
               SIGNED_EN ? 2 : 67, 0, 1'b1);
        run_op("5/9", 64'd5, 64'd9, 1'b0, 64'd0, 64'd5, 1'b0, 67, 0, 1'b1);
        run_op("0/3", 64'd0, 64'd3, 1'b0, 64'd0, 64'd0, 1'b0, 67, 1, 1'b0);
        run_op("max/2^63", ONES, SMIN, 1'b0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 67, 0, 1'b1);
        run_op("max/max", ONES, ONES, 1'b0, 64'd1, 64'd0, 1'b0, 67, 0, 1'b1);

        reset_mid_iter();
        run_op("max/1 after reset", ONES, 64'd1, 1'b0, ONES, 64'd0, 1'b0, 67, 0, 1'b1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
